decode_rep_sequencer: RTL and testbench
=======================================

# decode_rep_sequencer

Parametrised repeat-string sequencer for decode stage 1. It accepts one decoded string instruction carrying a REP, REPE or REPNE prefix and issues it downstream once per iteration. Each issued iteration writes back the decremented count register. For CMPS/SCAS it terminates on ZF feedback from execute, and it yields to pending interrupts at iteration boundaries. The block generalises the single-mode, fixed-width ECX repeat logic: configurable count width, 16/32-bit address-size counting, REPE/REPNE compare termination, and zero-count skip.

## Interface
- CNTW, 32, count register width (≥16)
- OPW, 16, opcode field width passed through
- ALLOW_INT, 1, 1 = yield to pending_int between iterations; 0 = never yield (hold_int stays 0)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  abort current instruction, return to IDLE
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  sequencer can accept
- in_rep  in  2  00 none, 01 REP/REPE (F3), 10 REPNE (F2), 11 treated as 00
- in_cmp  in  1  instruction is CMPS/SCAS (ZF termination applies)
- in_asize16  in  1  count uses low 16 bits only
- in_opcode  in  OPW  opcode
- in_count  in  CNTW  count register value at accept
- out_valid  out  1  iteration valid
- out_ready  in  1  downstream accepts iteration
- out_opcode  out  OPW  registered opcode
- out_last  out  1  issued iteration is known final (remaining count = 1)
- out_iter  out  CNTW  iteration index, 0-based
- zf_valid  in  1  execute reports ZF of the last compare iteration
- zf  in  1  ZF value
- cnt_wb_valid  out  1  count writeback strobe
- cnt_wb_data  out  CNTW  new count register value
- pending_int  in  1  interrupt pending
- hold_int  out  1  interrupt must wait (mid-flag-wait)
- int_yield  out  1  one-cycle pulse: instruction abandoned for interrupt, refetch same PC
- skip  out  1  one-cycle pulse: zero-count instruction retired without issue
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT_FLAG.
- IDLE: in_ready = ~flush. On accept, latch opcode, mode, cmp, asize16, and count (low 16 bits if asize16, else all CNTW bits). out_iter is cleared to 0.
  - in_rep none: go ISSUE with remaining = 1 and writeback disabled.
  - Effective count = 0: pulse skip next cycle, stay IDLE, no writeback.
  - Otherwise: go ISSUE.
- ISSUE: out_valid = 1 unless a yield applies.
  - Yield condition: ALLOW_INT & pending_int & out_iter ≠ 0.
  - On yield: out_valid = 0, int_yield pulses, go IDLE. No writeback, since the count is already architectural.
  - On out_valid & out_ready (rep mode): cnt_wb_valid = 1 with cnt_wb_data = remaining − 1. In asize16 mode the upper CNTW−16 bits keep in_count's upper bits and the low 16 bits wrap modulo 2^16. out_iter is incremented.
    - If remaining − 1 = 0: go IDLE.
    - Else if cmp & mode ≠ none: go WAIT_FLAG.
    - Else: stay ISSUE.
- WAIT_FLAG: out_valid = 0. hold_int = pending_int. On zf_valid:
  - Terminate to IDLE if (REPE and zf = 0) or (REPNE and zf = 1).
  - Otherwise go ISSUE.
- out_last = (remaining = 1), independent of ZF.
- flush: has priority over every event in the same cycle. It forces out_valid = 0, in_ready = 0, cnt_wb_valid = 0, and the next state is IDLE. Writebacks from earlier cycles stand.

## Timing
- All state is registered. out_valid, out_ready, in_ready, cnt_wb_valid, hold_int and int_yield are combinational from state and inputs. skip is registered.
- Accept at cycle N gives first out_valid at N+1.
- Back-to-back iterations issue every cycle while out_ready = 1 (non-cmp).
- Cmp instructions issue at most one iteration per zf_valid. zf_valid may arrive in the cycle after issue at the earliest.
- cnt_wb_valid is asserted in the same cycle as the out handshake.
- out_valid is held with stable payload until out_ready.
- Reset (reset = 0 at a clock edge): state IDLE, remaining/out_iter/opcode = 0, and all outputs 0, including in_ready. in_ready rises to 1 in the first cycle after reset deasserts.
- Reset mid-instruction discards all state with no writeback.
- zf_valid outside WAIT_FLAG is ignored.
- pending_int in IDLE has no effect.
- Yield is never taken before the first iteration (forward-progress guarantee).
- Count 2^CNTW−1 is legal; the decrement never underflows because zero is filtered at accept.

## Test plan
- REP MOVS, count 3, out_ready = 1: out_valid on 3 consecutive cycles; wb data 2, 1, 0; out_iter 0, 1, 2; out_last on the third; busy drops after.
- REP STOS, count 0: in accepted, skip pulses once, no out_valid, no cnt_wb_valid.
- REPE CMPS, count 5, zf = 1, 1, 0: 3 iterations, wb 4, 3, 2, then IDLE. REPNE CMPS with zf = 1 on the first compare: 1 iteration, wb 4.
- REP MOVS, count 10, pending_int raised after iteration 2: int_yield pulse, out_valid = 0, last wb = 8, in_ready = 1 the next cycle. With ALLOW_INT = 0: all 10 iterations complete.
- asize16, in_count 0xABCD0000: skip. in_count 0xABCD0001: one iteration, wb 0xABCD0000.
- out_ready held 0 for 4 cycles mid-REP, then flush: payload stable while stalled, flush cycle out_valid = 0, no further wb, IDLE next. Reset asserted mid-ISSUE: all outputs 0.

Source files
------------

// File: rtl/decode_rep_sequencer.sv
// Repeat-string sequencer for decode stage 1: issues one REP/REPE/REPNE string
// instruction downstream once per iteration and writes back the decremented count.
module decode_rep_sequencer #(
    parameter int CNTW      = 32,
    parameter int OPW       = 16,
    parameter bit ALLOW_INT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_rep,
    input  logic            in_cmp,
    input  logic            in_asize16,
    input  logic [OPW-1:0]  in_opcode,
    input  logic [CNTW-1:0] in_count,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  out_opcode,
    output logic            out_last,
    output logic [CNTW-1:0] out_iter,
    input  logic            zf_valid,
    input  logic            zf,
    output logic            cnt_wb_valid,
    output logic [CNTW-1:0] cnt_wb_data,
    input  logic            pending_int,
    output logic            hold_int,
    output logic            int_yield,
    output logic            skip,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FLAG} state_t;
    typedef enum logic [1:0] {MODE_NONE, MODE_REPE, MODE_REPNE} mode_t;

    localparam logic [CNTW-1:0] LOW_MASK = CNTW'(16'hFFFF);

    state_t          state, next_state;
    mode_t           mode, in_mode;
    logic            cmp, asize16;
    logic [CNTW-1:0] remaining, hi_keep, eff_count, dec, wb_value;
    logic            accept, fire, yield_cond, terminate;

    always_comb begin
        case (in_rep)
            2'b01:   in_mode = MODE_REPE;
            2'b10:   in_mode = MODE_REPNE;
            default: in_mode = MODE_NONE;
        endcase
    end

    assign eff_count  = in_asize16 ? (in_count & LOW_MASK) : in_count;
    assign dec        = remaining - CNTW'(1);
    // Address-size-16 counting only touches the low half; the upper bits are architectural and pass through.
    assign wb_value   = asize16 ? ((hi_keep & ~LOW_MASK) | (dec & LOW_MASK)) : dec;
    assign yield_cond = ALLOW_INT && pending_int && (out_iter != '0);
    assign terminate  = ((mode == MODE_REPE) && !zf) || ((mode == MODE_REPNE) && zf);
    assign out_last   = (remaining == CNTW'(1));
    assign busy       = (state != IDLE);
    assign cnt_wb_data = cnt_wb_valid ? wb_value : '0;

    always_comb begin
        next_state   = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        cnt_wb_valid = 1'b0;
        hold_int     = 1'b0;
        int_yield    = 1'b0;
        accept       = 1'b0;
        fire         = 1'b0;
        if (!reset || flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept = 1'b1;
                        if (in_mode != MODE_NONE && eff_count == '0)
                            next_state = IDLE;
                        else
                            next_state = ISSUE;
                    end
                end
                ISSUE: begin
                    if (yield_cond) begin
                        int_yield  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        out_valid = 1'b1;
                        if (out_ready) begin
                            fire         = 1'b1;
                            cnt_wb_valid = (mode != MODE_NONE);
                            if (dec == '0)
                                next_state = IDLE;
                            else if (cmp && mode != MODE_NONE)
                                next_state = WAIT_FLAG;
                        end
                    end
                end
                WAIT_FLAG: begin
                    hold_int = ALLOW_INT && pending_int;
                    if (zf_valid)
                        next_state = terminate ? IDLE : ISSUE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            mode       <= MODE_NONE;
            cmp        <= 1'b0;
            asize16    <= 1'b0;
            remaining  <= '0;
            hi_keep    <= '0;
            out_iter   <= '0;
            out_opcode <= '0;
            skip       <= 1'b0;
        end else begin
            state <= next_state;
            skip  <= accept && (in_mode != MODE_NONE) && (eff_count == '0);
            if (accept) begin
                out_opcode <= in_opcode;
                mode       <= in_mode;
                cmp        <= in_cmp;
                asize16    <= in_asize16;
                hi_keep    <= in_count & ~LOW_MASK;
                out_iter   <= '0;
                // A prefix-less instruction issues exactly once regardless of the count register.
                remaining  <= (in_mode == MODE_NONE) ? CNTW'(1) : eff_count;
            end
            if (fire) begin
                remaining <= dec;
                out_iter  <= out_iter + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_rep_sequencer.sv
// Directed bench for decode_rep_sequencer: per-cycle vector table plus hand-written
// sequences for interrupt yield, stall/flush and mid-instruction reset.
module tb_decode_rep_sequencer;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_cmp, in_asize16, out_ready;
    logic        zf_valid, zf, pending_int;
    logic [1:0]  in_rep;
    logic [15:0] in_opcode;
    logic [31:0] in_count;

    logic        in_ready, out_valid, out_last, cnt_wb_valid, hold_int, int_yield, skip, busy;
    logic [15:0] out_opcode;
    logic [31:0] out_iter, cnt_wb_data;

    logic        ni_in_ready, ni_out_valid, ni_out_last, ni_cnt_wb_valid, ni_hold_int;
    logic        ni_int_yield, ni_skip, ni_busy;
    logic [15:0] ni_out_opcode;
    logic [31:0] ni_out_iter, ni_cnt_wb_data;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_rep_sequencer #(.CNTW(32), .OPW(16), .ALLOW_INT(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rep(in_rep), .in_cmp(in_cmp), .in_asize16(in_asize16), .in_opcode(in_opcode),
        .in_count(in_count), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_last(out_last), .out_iter(out_iter),
        .zf_valid(zf_valid), .zf(zf), .cnt_wb_valid(cnt_wb_valid), .cnt_wb_data(cnt_wb_data),
        .pending_int(pending_int), .hold_int(hold_int), .int_yield(int_yield),
        .skip(skip), .busy(busy)
    );

    decode_rep_sequencer #(.CNTW(32), .OPW(16), .ALLOW_INT(1'b0)) dut_ni (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ni_in_ready),
        .in_rep(in_rep), .in_cmp(in_cmp), .in_asize16(in_asize16), .in_opcode(in_opcode),
        .in_count(in_count), .out_valid(ni_out_valid), .out_ready(out_ready),
        .out_opcode(ni_out_opcode), .out_last(ni_out_last), .out_iter(ni_out_iter),
        .zf_valid(zf_valid), .zf(zf), .cnt_wb_valid(ni_cnt_wb_valid),
        .cnt_wb_data(ni_cnt_wb_data), .pending_int(pending_int), .hold_int(ni_hold_int),
        .int_yield(ni_int_yield), .skip(ni_skip), .busy(ni_busy)
    );

    typedef struct {
        logic        rst, fl, iv;
        logic [1:0]  rep;
        logic        cmp, a16;
        logic [15:0] op;
        logic [31:0] cnt;
        logic        ordy, zfv, zfb, pint;
        logic        e_ir, e_ov, e_last;
        logic [31:0] e_iter;
        logic [15:0] e_op;
        logic        e_wb;
        logic [31:0] e_wbd;
        logic        e_y, e_h, e_skip, e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, fl, iv, input logic [1:0] rep, input logic cmp, a16,
        input logic [15:0] op, input logic [31:0] cnt, input logic ordy, zfv, zfb, pint,
        input logic e_ir, e_ov, e_last, input logic [31:0] e_iter, input logic [15:0] e_op,
        input logic e_wb, input logic [31:0] e_wbd, input logic e_y, e_h, e_skip, e_busy);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.rep = rep; v.cmp = cmp; v.a16 = a16;
        v.op = op; v.cnt = cnt; v.ordy = ordy; v.zfv = zfv; v.zfb = zfb; v.pint = pint;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_last = e_last; v.e_iter = e_iter; v.e_op = e_op;
        v.e_wb = e_wb; v.e_wbd = e_wbd; v.e_y = e_y; v.e_h = e_h; v.e_skip = e_skip;
        v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset = v.rst; flush = v.fl; in_valid = v.iv; in_rep = v.rep; in_cmp = v.cmp;
        in_asize16 = v.a16; in_opcode = v.op; in_count = v.cnt; out_ready = v.ordy;
        zf_valid = v.zfv; zf = v.zfb; pending_int = v.pint;
    endtask

    task automatic drive_idle();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rep = 2'b00; in_cmp = 1'b0;
        in_asize16 = 1'b0; in_opcode = 16'h0; in_count = 32'h0; out_ready = 1'b1;
        zf_valid = 1'b0; zf = 1'b0; pending_int = 1'b0;
    endtask

    task automatic drive_accept(input logic [15:0] op, input logic [31:0] cnt);
        drive_idle();
        in_valid = 1'b1; in_rep = 2'b01; in_opcode = op; in_count = cnt;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int exp_it;
        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);

        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,           1,0,0,0,0,0,0,0,0,0,0));
        // REP MOVS count 3
        tbl.push_back(mk(1,0,1,2'b01,0,0,16'hA5A5,3,1,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           0,1,0,0,16'hA5A5,1,2,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           0,1,0,1,16'hA5A5,1,1,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           0,1,1,2,16'hA5A5,1,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           1,0,0,0,0,0,0,0,0,0,0));
        // REP STOS count 0
        tbl.push_back(mk(1,0,1,2'b01,0,0,16'hAAAA,0,1,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           1,0,0,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           1,0,0,0,0,0,0,0,0,0,0));
        // REPE CMPS count 5, zf 1,1,0
        tbl.push_back(mk(1,0,1,2'b01,1,0,16'hA6A6,5,1,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           0,1,0,0,16'hA6A6,1,4,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,1,           0,0,0,0,0,0,0,0,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1,1,0,           0,0,0,0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           0,1,0,1,16'hA6A6,1,3,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1,1,0,           0,0,0,0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           0,1,0,2,16'hA6A6,1,2,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1,0,0,           0,0,0,0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           1,0,0,0,0,0,0,0,0,0,0));
        // REPNE CMPS count 5, zf 1 on first compare; zf_valid during ISSUE ignored
        tbl.push_back(mk(1,0,1,2'b10,1,0,16'hAEAE,5,1,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1,1,0,           0,1,0,0,16'hAEAE,1,4,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1,1,0,           0,0,0,0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,1,           1,0,0,0,0,0,0,0,0,0,0));
        // asize16 counts
        tbl.push_back(mk(1,0,1,2'b01,0,1,16'h1111,32'hABCD0000,1,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           1,0,0,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,1,2'b01,0,1,16'h1111,32'hABCD0001,1,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           0,1,1,0,16'h1111,1,32'hABCD0000,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           1,0,0,0,0,0,0,0,0,0,0));
        // no prefix (00 and 11): one issue, no writeback, zero count not skipped
        tbl.push_back(mk(1,0,1,2'b00,0,0,16'h2222,0,1,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           0,1,1,0,16'h2222,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           1,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1,2'b11,0,0,16'h5555,7,1,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           0,1,1,0,16'h5555,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           1,0,0,0,0,0,0,0,0,0,0));
        // maximum count, then flush
        tbl.push_back(mk(1,0,1,2'b01,0,0,16'h3333,32'hFFFFFFFF,1,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           0,1,0,0,16'h3333,1,32'hFFFFFFFE,0,0,0,1));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,1,0,0,0,           0,0,0,0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,           1,0,0,0,0,0,0,0,0,0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            apply_stimulus(tbl[i]);
            #2;
            check_output($sformatf("r%0d in_ready", i), in_ready, tbl[i].e_ir);
            check_output($sformatf("r%0d out_valid", i), out_valid, tbl[i].e_ov);
            check_output($sformatf("r%0d cnt_wb_valid", i), cnt_wb_valid, tbl[i].e_wb);
            check_output($sformatf("r%0d int_yield", i), int_yield, tbl[i].e_y);
            check_output($sformatf("r%0d hold_int", i), hold_int, tbl[i].e_h);
            check_output($sformatf("r%0d skip", i), skip, tbl[i].e_skip);
            check_output($sformatf("r%0d busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_ov) begin
                check_output($sformatf("r%0d out_iter", i), out_iter, tbl[i].e_iter);
                check_output($sformatf("r%0d out_last", i), out_last, tbl[i].e_last);
                check_output($sformatf("r%0d out_opcode", i), out_opcode, tbl[i].e_op);
            end
            if (tbl[i].e_wb)
                check_output($sformatf("r%0d cnt_wb_data", i), cnt_wb_data, tbl[i].e_wbd);
        end

        // REP MOVS count 10, interrupt pending from the third iteration on
        @(negedge clk); drive_accept(16'h7777, 32'd10);
        @(negedge clk); drive_idle(); #2;
        check_output("yield it0 wb", cnt_wb_data, 32'd9);
        @(negedge clk); #2;
        check_output("yield it1 wb", cnt_wb_data, 32'd8);
        @(negedge clk); pending_int = 1'b1; #2;
        check_output("yield pulse", int_yield, 1'b1);
        check_output("yield out_valid", out_valid, 1'b0);
        check_output("yield wb_valid", cnt_wb_valid, 1'b0);
        check_output("noint out_valid", ni_out_valid, 1'b1);
        check_output("noint it2 wb", ni_cnt_wb_data, 32'd7);
        check_output("noint int_yield", ni_int_yield, 1'b0);
        @(negedge clk); pending_int = 1'b0; #2;
        check_output("yield in_ready after", in_ready, 1'b1);
        check_output("yield busy after", busy, 1'b0);
        exp_it = 3;
        for (int c = 0; c < 12 && ni_busy; c++) begin
            if (ni_out_valid) begin
                check_output($sformatf("noint iter%0d", exp_it), ni_out_iter, exp_it);
                check_output($sformatf("noint wb%0d", exp_it), ni_cnt_wb_data, 32'(9 - exp_it));
                check_output($sformatf("noint last%0d", exp_it), ni_out_last, exp_it == 9);
                exp_it++;
            end
            @(negedge clk); #2;
        end
        check_output("noint iterations", exp_it, 10);
        check_output("noint idle", ni_busy, 1'b0);

        // Forward progress: interrupt pending from accept still lets iteration 0 issue
        @(negedge clk); drive_accept(16'h8888, 32'd2); pending_int = 1'b1;
        @(negedge clk); in_valid = 1'b0; #2;
        check_output("fp it0 out_valid", out_valid, 1'b1);
        check_output("fp it0 int_yield", int_yield, 1'b0);
        check_output("fp it0 wb", cnt_wb_data, 32'd1);
        @(negedge clk); #2;
        check_output("fp it1 int_yield", int_yield, 1'b1);
        check_output("fp it1 out_valid", out_valid, 1'b0);
        @(negedge clk); pending_int = 1'b0; #2;
        check_output("fp in_ready", in_ready, 1'b1);

        // Stall for four cycles, then flush
        @(negedge clk); drive_accept(16'h4444, 32'd6);
        @(negedge clk); drive_idle(); #2;
        check_output("stall it0 wb", cnt_wb_data, 32'd5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); out_ready = 1'b0; #2;
            check_output($sformatf("stall%0d out_valid", c), out_valid, 1'b1);
            check_output($sformatf("stall%0d out_iter", c), out_iter, 32'd1);
            check_output($sformatf("stall%0d out_opcode", c), out_opcode, 16'h4444);
            check_output($sformatf("stall%0d wb_valid", c), cnt_wb_valid, 1'b0);
        end
        @(negedge clk); out_ready = 1'b1; flush = 1'b1; #2;
        check_output("flush out_valid", out_valid, 1'b0);
        check_output("flush wb_valid", cnt_wb_valid, 1'b0);
        check_output("flush in_ready", in_ready, 1'b0);
        @(negedge clk); flush = 1'b0; #2;
        check_output("post-flush busy", busy, 1'b0);
        check_output("post-flush in_ready", in_ready, 1'b1);
        check_output("post-flush out_valid", out_valid, 1'b0);

        // Reset asserted mid-ISSUE
        @(negedge clk); drive_accept(16'h9999, 32'd6);
        @(negedge clk); drive_idle(); #2;
        check_output("rst it0 out_valid", out_valid, 1'b1);
        @(negedge clk); reset = 1'b0; #2;
        check_output("rst edge wb_valid", cnt_wb_valid, 1'b0);
        check_output("rst edge in_ready", in_ready, 1'b0);
        @(negedge clk); #2;
        check_output("rst busy", busy, 1'b0);
        check_output("rst in_ready", in_ready, 1'b0);
        check_output("rst out_valid", out_valid, 1'b0);
        check_output("rst out_iter", out_iter, 32'd0);
        check_output("rst out_opcode", out_opcode, 16'h0);
        check_output("rst out_last", out_last, 1'b0);
        check_output("rst wb_data", cnt_wb_data, 32'd0);
        check_output("rst skip", skip, 1'b0);
        @(negedge clk); reset = 1'b1; #2;
        check_output("rst release in_ready", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
